// File: rtl/uart_msg_scheduler.sv
// Byte-level TX scheduler: periodic/on-demand banner plus buffered echo of RX bytes.
// Banners and echo bytes never interleave; the echo transform is applied at the output.
module uart_msg_scheduler #(
    parameter int unsigned          MSG_LEN    = 15,
    parameter logic [MSG_LEN*8-1:0] MSG        = {"Tang Nano 20K", 8'h0d, 8'h0a},
    parameter int unsigned          PERIOD     = 27_000_000,
    parameter int unsigned          FIFO_DEPTH = 16,
    parameter int unsigned          ECHO_MODE  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            banner_req,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic [7:0]                      tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    input  logic                            ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic                            banner_busy
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BANNER = 2'd1;
    localparam logic [1:0] ST_ECHO   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic          pend_q, pend_d;
    logic [PW-1:0] per_cnt_q, per_cnt_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    txd_q, txd_d;
    logic          txv_q, txv_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic xfer_s, pop_s, push_req_s, full_s, push_s, drop_s, tick_s, start_s;

    function automatic logic [7:0] msg_byte(input logic [7:0] i);
        return MSG[(MSG_LEN - 1 - 32'(i)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] echo_xform(input logic [7:0] b);
        logic [7:0] r;
        if (ECHO_MODE == 2 && b >= 8'h61 && b <= 8'h7a) begin
            r = b - 8'h20;
        end else begin
            r = b;
        end
        return r;
    endfunction

    assign xfer_s     = txv_q && tx_ready;
    assign pop_s      = (state_q == ST_ECHO) && xfer_s;
    assign push_req_s = rx_valid && (ECHO_MODE != 0);
    assign full_s     = (level_q == (AW+1)'(FIFO_DEPTH));
    assign push_s     = push_req_s && (!full_s || pop_s);
    assign drop_s     = push_req_s && full_s && !pop_s;
    assign tick_s     = (PERIOD != 0) && (per_cnt_q == PW'(PERIOD - 1));

    // Scheduler FSM and output byte register
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        txd_d   = txd_q;
        txv_d   = txv_q;
        start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d = ST_BANNER;
                    idx_d   = 8'd0;
                    txd_d   = msg_byte(8'd0);
                    txv_d   = 1'b1;
                    start_s = 1'b1;
                end else if (level_q != '0) begin
                    state_d = ST_ECHO;
                    txd_d   = echo_xform(mem_q[rptr_q]);
                    txv_d   = 1'b1;
                end else begin
                    txv_d   = 1'b0;
                end
            end
            ST_BANNER: begin
                if (xfer_s && idx_q == 8'(MSG_LEN - 1)) begin
                    state_d = ST_IDLE;
                    txv_d   = 1'b0;
                end else if (xfer_s) begin
                    idx_d   = idx_q + 8'd1;
                    txd_d   = msg_byte(idx_q + 8'd1);
                end else begin
                    txv_d   = 1'b1;
                end
            end
            ST_ECHO: begin
                if (xfer_s) begin
                    state_d = ST_IDLE;
                    txv_d   = 1'b0;
                end else begin
                    txv_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txv_d   = 1'b0;
            end
        endcase
    end

    // A request landing while the pending flag is being consumed merges into that banner
    always_comb begin
        if (start_s) begin
            pend_d = 1'b0;
        end else if (banner_req || tick_s) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end
        if (PERIOD == 0 || tick_s) begin
            per_cnt_d = '0;
        end else begin
            per_cnt_d = per_cnt_q + PW'(1);
        end
    end

    // Echo FIFO pointers, occupancy and sticky overflow
    always_comb begin
        wptr_d = push_s ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop_s  ? rptr_q + AW'(1) : rptr_q;
        if (push_s && !pop_s) begin
            level_d = level_q + (AW+1)'(1);
        end else if (pop_s && !push_s) begin
            level_d = level_q - (AW+1)'(1);
        end else begin
            level_d = level_q;
        end
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 8'd0;
            pend_q    <= 1'b1;
            per_cnt_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            txd_q     <= 8'd0;
            txv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            per_cnt_q <= per_cnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            txd_q     <= txd_d;
            txv_q     <= txv_d;
        end
    end

    // FIFO storage needs no reset; occupancy guards every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= rx_data;
        end
    end

    assign tx_data     = txd_q;
    assign tx_valid    = txv_q;
    assign fifo_level  = level_q;
    assign overflow    = ovf_q;
    assign banner_busy = (state_q == ST_BANNER);
endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Scoreboard bench for uart_msg_scheduler: directed scenarios followed by random traffic,
// checked against a transaction-level model of the banner/echo scheduling rules.
module tb_uart_msg_scheduler;
    localparam int MLEN  = 3;
    localparam int PER   = 100;
    localparam int DEPTH = 4;

    logic       clk, rst, banner_req, rx_valid, tx_ready, ovf_clr;
    logic [7:0] rx_data, tx_data;
    logic       tx_valid, overflow, banner_busy;
    logic [2:0] fifo_level;

    uart_msg_scheduler #(
        .MSG_LEN(MLEN), .MSG({"AB", 8'h0a}), .PERIOD(PER),
        .FIFO_DEPTH(DEPTH), .ECHO_MODE(2)
    ) dut (
        .clk(clk), .rst(rst), .banner_req(banner_req), .rx_data(rx_data),
        .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ovf_clr(ovf_clr), .fifo_level(fifo_level),
        .overflow(overflow), .banner_busy(banner_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] msg_bytes [MLEN] = '{8'h41, 8'h42, 8'h0a};
    logic [7:0] fq [$];
    bit   pend, ovf, exp_start, exp_echo;
    bit   p_txv, p_xfer, p_busy, p_cont;
    logic [7:0] p_data;
    int   cyc, bpos, last_start, gap_last;

    function automatic logic [7:0] upcase(input logic [7:0] b);
        if (b >= "a" && b <= "z") return b - 8'd32;
        return b;
    endfunction

    // Monitor: verify the previous edge's effects, then predict the next edge
    always @(negedge clk) begin
        bit idle, xfer, cont, pop, drop, tick;
        if (rst) begin
            fq.delete();
            pend = 1; ovf = 0; exp_start = 0; exp_echo = 0;
            p_txv = 0; p_xfer = 0; p_busy = 0; p_cont = 0; p_data = 8'h00;
            cyc = 0; bpos = 0; last_start = -1;
        end else begin
            chk("fifo_level", 32'(fifo_level), 32'(fq.size()));
            chk("overflow", 32'(overflow), 32'(ovf));
            if (!p_txv) begin
                chk("idle_busy", 32'(banner_busy), 32'(exp_start));
                chk("idle_valid", 32'(tx_valid), 32'(exp_start | exp_echo));
            end else if (!p_xfer) begin
                chk("hold", {22'd0, tx_valid, banner_busy, tx_data}, {22'd0, 1'b1, p_busy, p_data});
            end else if (p_cont) begin
                chk("banner_cont", {30'd0, tx_valid, banner_busy}, 32'd3);
            end else begin
                chk("after_last", {30'd0, tx_valid, banner_busy}, 32'd0);
            end
            if (banner_busy && !p_busy) begin
                if (last_start >= 0) gap_last = cyc - last_start;
                last_start = cyc;
            end

            idle = !tx_valid;
            xfer = tx_valid && tx_ready;
            cont = 0; pop = 0; drop = 0;
            if (xfer && banner_busy) begin
                chk("banner_byte", 32'(tx_data), 32'(msg_bytes[bpos]));
                bpos++;
                if (bpos == MLEN) bpos = 0;
                else cont = 1;
            end else if (xfer) begin
                if (fq.size() == 0) begin
                    chk("echo_avail", 32'd0, 32'd1);
                end else begin
                    chk("echo_byte", 32'(tx_data), 32'(upcase(fq[0])));
                    pop = 1;
                end
            end
            exp_start = idle && pend;
            exp_echo  = idle && !pend && fq.size() != 0;
            if (pop) void'(fq.pop_front());
            if (rx_valid) begin
                if (fq.size() < DEPTH) fq.push_back(rx_data);
                else drop = 1;
            end
            ovf  = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf);
            tick = (cyc % PER) == PER - 1;
            cyc++;
            pend = exp_start ? 1'b0 : (pend | banner_req | tick);
            p_txv = tx_valid; p_xfer = xfer; p_busy = banner_busy;
            p_data = tx_data; p_cont = cont;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_req();
        banner_req = 1'b1;
        step(1);
        banner_req = 1'b0;
    endtask

    task automatic wait_busy();
        int k = 0;
        while (!banner_busy && k < 300) begin
            step(1);
            k++;
        end
        if (!banner_busy) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_banner: no banner within 300 cycles");
        end
    endtask

    initial begin
        gap_last = -1;
        rst = 1'b1; banner_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        tx_ready = 1'b0; ovf_clr = 1'b0;
        step(3);
        chk("rst_outputs", {19'd0, tx_valid, banner_busy, overflow, fifo_level, tx_data}, 32'd0);
        tx_ready = 1'b1;
        rst = 1'b0;
        step(10);

        push(8'h61);
        step(6);
        push(8'h7a); push(8'h7b); push(8'h31);
        step(10);

        wait_busy();
        tx_ready = 1'b0;
        step(20);
        tx_ready = 1'b1;
        step(10);

        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
        step(1);
        chk("ovf_full_level", 32'(fifo_level), 32'd4);
        chk("ovf_set", 32'(overflow), 32'd1);
        tx_ready = 1'b1;
        step(12);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        tx_ready = 1'b0;
        push(8'h41); push(8'h62); push(8'h63);
        tx_ready = 1'b1;
        step(1);
        pulse_req();
        step(15);

        step(250);
        chk("banner_period", 32'(gap_last), 32'd100);

        wait_busy();
        pulse_req();
        step(1);
        pulse_req();
        step(20);

        wait_busy();
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {30'd0, tx_valid, banner_busy}, 32'd0);
        step(2);
        rst = 1'b0;
        step(10);

        for (int i = 0; i < 3000; i++) begin
            rx_valid   = ($urandom_range(0, 99) < 30);
            rx_data    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'h61, 8'h7a))
                                                      : 8'($urandom_range(0, 255));
            tx_ready   = ($urandom_range(0, 99) < 70);
            banner_req = ($urandom_range(0, 99) < 3);
            ovf_clr    = ($urandom_range(0, 99) < 5);
            step(1);
        end
        rx_valid = 1'b0; banner_req = 1'b0; ovf_clr = 1'b0; tx_ready = 1'b1;
        step(60);
        chk("final_level", 32'(fifo_level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_msg_scheduler.md
Name: uart_msg_scheduler

Overview:
- Byte-level transmit scheduler that sits between the UART RX/TX byte engines and the board top.
- Sends a parametrised banner string periodically or on demand, and echoes received bytes through a buffering FIFO instead of dropping them.
- Banners are never interleaved with echo bytes.
- Generalises the fixed-string / unbuffered-echo top with configurable message, period, FIFO depth and echo mode.

Parameters:
- MSG_LEN, 15, banner length in bytes (1..255).
- MSG, "Tang Nano 20K" followed by 8'h0d 8'h0a, MSG_LEN*8-bit banner; the MSB byte is sent first.
- PERIOD, 27_000_000, clock cycles between automatic banner requests; 0 disables automatic banners.
- FIFO_DEPTH, 16, echo FIFO entries; must be a power of two, at least 2.
- ECHO_MODE, 1, 0 = echo off, 1 = echo verbatim, 2 = echo with ASCII a-z converted to A-Z.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- banner_req  in  1  one-cycle pulse; requests a banner
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid
- tx_data  out  8  byte to the TX engine
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  TX engine accepts when high with tx_valid
- ovf_clr  in  1  clears overflow
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: an RX byte was dropped
- banner_busy  out  1  high while in BANNER state

Behaviour:
- Reset (async, rst=1): all outputs are 0 and tx_data=0.
  - State is IDLE, FIFO is empty, period counter is 0, banner pending flag is set.
  - Result: a banner is sent right after reset.
- Handshake:
  - A transfer occurs on a clk edge with tx_valid && tx_ready.
  - Once tx_valid rises, tx_data must be held stable and tx_valid held high until transfer.
  - After a transfer, the next byte may be presented on the following cycle; there is no mandatory bubble.
- Period counter:
  - Free-runs 0..PERIOD-1 and wraps.
  - At PERIOD-1 it sets the pending flag.
  - banner_req also sets the pending flag.
  - Requests while pending is already set merge; there is no queueing beyond one.
- State IDLE:
  - If pending: go to BANNER, clear pending, index=0. Pending has priority over a non-empty FIFO.
  - Else if FIFO is not empty: go to ECHO.
- State BANNER:
  - Presents MSG byte[index]; index advances on each transfer.
  - On the transfer of byte MSG_LEN-1: go to IDLE.
  - Requests arriving during BANNER set pending; they do not restart the current banner.
- State ECHO:
  - Presents the FIFO head, transformed per ECHO_MODE. The transform is applied at the output, not at push.
  - Pops on transfer, then returns to IDLE.
  - One byte per visit, so a pending banner is served after at most one echo byte.
- FIFO:
  - Push when rx_valid && ECHO_MODE!=0 && (not full, or a pop in the same cycle).
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Push while full with no pop: the byte is dropped and overflow is set.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level is registered and reflects the state after the edge.
- overflow:
  - Cleared by ovf_clr.
  - If ovf_clr and a drop occur in the same cycle, the set wins.
- ECHO_MODE=0: rx_valid is ignored, the FIFO stays empty, and the ECHO state is unreachable.
- Reset mid-transfer: tx_valid drops immediately. A partial banner is not resumed; a fresh banner follows after reset.

Test Plan:
1. MSG_LEN=3, MSG="AB\n", PERIOD=0, tx_ready tied 1, release rst -> tx_data 8'h41, 8'h42, 8'h0a on 3 consecutive transfer cycles; then tx_valid=0, banner_busy 1->0.
2. After idle, rx_valid with 8'h61 and ECHO_MODE=2 -> a single transfer of 8'h41, fifo_level 1->0. With ECHO_MODE=1 -> 8'h61.
3. Backpressure: tx_ready held 0 for 20 cycles during the banner -> tx_valid stays 1 and tx_data stays 8'h41; the sequence resumes unchanged when tx_ready=1.
4. FIFO_DEPTH=4, tx_ready=0, push 6 bytes 8'h30..8'h35 -> fifo_level=4 and overflow=1. After tx_ready=1 -> echoes 8'h30..8'h33 only. ovf_clr -> overflow=0.
5. Interleave: FIFO holds 3 bytes and banner_req pulses during the first echo -> output is echo byte 1, full banner, then echo bytes 2 and 3.
6. PERIOD=100, no other stimulus -> banner starts 100 cycles apart. banner_req pulsed twice during a banner -> exactly one extra banner follows.
